seg_scan_decoder: RTL

- Reads back a time-multiplexed seven-segment display bus (active-low anodes plus active-low cathodes) and recovers the 4-bit code shown on each digit.
- Used as a self-test observer beside the display driver: it snoops the same anode/cathode nets that go to the board and exposes the per-digit codes and a frame-complete strobe to the checker logic.

---
 rtl/seg_scan_decoder.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Observes a time-multiplexed seven-segment display bus, which uses active-low
// anodes and active-low cathodes, and recovers the 4-bit code shown on each
// digit. It sits beside the display driver and snoops the same nets. The
// per-digit codes and capture strobes feed the self-test checker.
//
// Parameters:
//   NUM_DIGITS    - number of anode lines scanned (1..8)
//   STABLE_CYCLES - consecutive clocks a bus value must hold before capture
//                   (2..255)
//
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   anode       - active-low digit enables, bit i selects digit i
//   cathode     - active-low segments {a,b,c,d,e,f,g,dp}
//   digits      - registered code per digit, digit i at [4i+3:4i]
//   digit_valid - digit i captured at least once since reset
//   cap_strobe  - one-cycle pulse on each capture
//   cap_index   - index of the digit just captured
//   cap_code    - code just captured
//   code_err    - one-cycle pulse when a captured pattern is not in the table
//   anode_err   - one-cycle pulse when a stable window has several anodes low
//   frame_done  - one-cycle pulse when every digit has been captured since
//                 the previous frame_done
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [7:0]              cathode,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    cap_strobe,
    output logic [2:0]              cap_index,
    output logic [3:0]              cap_code,
    output logic                    code_err,
    output logic                    anode_err,
    output logic                    frame_done
);

    localparam int         SW       = NUM_DIGITS + 8;
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    // The result is {not_in_table, code}. Unknown patterns decode to E.
    function automatic logic [4:0] decode_cathode(input logic [7:0] pat);
        logic [4:0] res;
        case (pat)
            8'b0000_0011: res = {1'b0, 4'h0};
            8'b1001_1111: res = {1'b0, 4'h1};
            8'b0010_0101: res = {1'b0, 4'h2};
            8'b0000_1101: res = {1'b0, 4'h3};
            8'b1001_1001: res = {1'b0, 4'h4};
            8'b0100_1001: res = {1'b0, 4'h5};
            8'b0100_0001: res = {1'b0, 4'h6};
            8'b0001_1111: res = {1'b0, 4'h7};
            8'b0000_0001: res = {1'b0, 4'h8};
            8'b0000_1001: res = {1'b0, 4'h9};
            8'b1111_1110: res = {1'b0, 4'hA};
            8'b0011_0001: res = {1'b0, 4'hB};
            8'b1111_1111: res = {1'b0, 4'hF};
            default:      res = {1'b1, 4'hE};
        endcase
        return res;
    endfunction

    // Returns the number of low anode lines.
    function automatic logic [3:0] count_low(input logic [NUM_DIGITS-1:0] an);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) begin
                cnt = cnt + 4'd1;
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // Returns the index of the lowest low anode line.
    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!an[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Synchronizer stages. They reset to all ones, which means blank and no digit.
    logic [NUM_DIGITS-1:0]   anode_s1_q, anode_s2_q;
    logic [7:0]              cathode_s1_q, cathode_s2_q;

    // Stability tracking state
    logic [SW-1:0]           sample_q, sample_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    used_q, used_d;

    // Output and frame state
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    cap_strobe_q, cap_strobe_d;
    logic [2:0]              cap_index_q, cap_index_d;
    logic [3:0]              cap_code_q, cap_code_d;
    logic                    code_err_q, code_err_d;
    logic                    anode_err_q, anode_err_d;
    logic                    frame_done_q, frame_done_d;

    // Combinational helpers
    logic [SW-1:0]           cur_s;
    logic                    event_s;
    logic [NUM_DIGITS-1:0]   win_anode_s;
    logic [NUM_DIGITS-1:0]   win_onehot_s;
    logic [3:0]              low_cnt_s;
    logic [4:0]              dec_s;
    logic [NUM_DIGITS-1:0]   mask_next_s;

    // Two-flop synchronizer on the snooped display bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_s1_q   <= '1;
            anode_s2_q   <= '1;
            cathode_s1_q <= 8'hFF;
            cathode_s2_q <= 8'hFF;
        end else begin
            anode_s1_q   <= anode;
            anode_s2_q   <= anode_s1_q;
            cathode_s1_q <= cathode;
            cathode_s2_q <= cathode_s1_q;
        end
    end

    // Stability counting, capture event detection and the next output state
    always_comb begin
        cur_s        = {anode_s2_q, cathode_s2_q};
        sample_d     = cur_s;
        cnt_d        = cnt_q;
        used_d       = used_q;
        digits_d     = digits_q;
        valid_d      = valid_q;
        mask_d       = mask_q;
        cap_strobe_d = 1'b0;
        cap_index_d  = cap_index_q;
        cap_code_d   = cap_code_q;
        code_err_d   = 1'b0;
        anode_err_d  = 1'b0;
        frame_done_d = 1'b0;

        // Classify the held sample, which is the value that has been stable.
        // The live value may change on the cycle the window completes.
        win_anode_s  = sample_q[SW-1:8];
        win_onehot_s = ~win_anode_s;
        low_cnt_s    = count_low(win_anode_s);
        dec_s        = decode_cathode(sample_q[7:0]);
        mask_next_s  = mask_q | win_onehot_s;

        event_s = (cnt_q == STABLE_C) && !used_q;

        if (cur_s != sample_q) begin
            cnt_d  = 8'd1;
            used_d = 1'b0;
        end else begin
            if (cnt_q < STABLE_C) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
            if (event_s) begin
                used_d = 1'b1;
            end else begin
                used_d = used_q;
            end
        end

        if (event_s) begin
            if (low_cnt_s == 4'd1) begin
                cap_strobe_d = 1'b1;
                cap_index_d  = low_index(win_anode_s);
                cap_code_d   = dec_s[3:0];
                code_err_d   = dec_s[4];
                valid_d      = valid_q | win_onehot_s;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (win_onehot_s[i]) begin
                        digits_d[4*i +: 4] = dec_s[3:0];
                    end else begin
                        digits_d[4*i +: 4] = digits_q[4*i +: 4];
                    end
                end
                // The frame closes only when every digit has been seen.
                // Repeat captures of a digit just refresh its mask bit.
                if (mask_next_s == {NUM_DIGITS{1'b1}}) begin
                    frame_done_d = 1'b1;
                    mask_d       = '0;
                end else begin
                    frame_done_d = 1'b0;
                    mask_d       = mask_next_s;
                end
            end else if (low_cnt_s == 4'd0) begin
                // A blanked interval is a normal part of scanning and is not an error.
                cap_strobe_d = 1'b0;
            end else begin
                anode_err_d = 1'b1;
            end
        end else begin
            cap_strobe_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q     <= '1;
            cnt_q        <= 8'd0;
            used_q       <= 1'b0;
            digits_q     <= '0;
            valid_q      <= '0;
            mask_q       <= '0;
            cap_strobe_q <= 1'b0;
            cap_index_q  <= 3'd0;
            cap_code_q   <= 4'd0;
            code_err_q   <= 1'b0;
            anode_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            cnt_q        <= cnt_d;
            used_q       <= used_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            mask_q       <= mask_d;
            cap_strobe_q <= cap_strobe_d;
            cap_index_q  <= cap_index_d;
            cap_code_q   <= cap_code_d;
            code_err_q   <= code_err_d;
            anode_err_q  <= anode_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign cap_strobe  = cap_strobe_q;
    assign cap_index   = cap_index_q;
    assign cap_code    = cap_code_q;
    assign code_err    = code_err_q;
    assign anode_err   = anode_err_q;
    assign frame_done  = frame_done_q;

endmodule
